i2c_target_rx: RTL

Write-only I2C target (slave) receiver for the I2C module. It is the far end of the bus driven by the SCL generator and master-side logic. It synchronises SCL/SDA into the system clock and detects START/STOP, matches a 7-bit address, shifts in data bytes MSB-first, and drives ACK on SDA through an open-drain enable. Received bytes are presented to local logic with a one-cycle valid strobe.

---
 rtl/i2c_target_rx.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: synchronises SCL/SDA, detects START/STOP, matches ADDR,
// shifts in data bytes MSB-first, ACKs through an open-drain enable and strobes each byte out.
module i2c_target_rx #(
    parameter logic [6:0] ADDR = 7'h2A
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } state_t;

    logic   scl_s1_q, scl_s2_q, scl_dly_q;
    logic   sda_s1_q, sda_s2_q, sda_dly_q;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       done_q, done_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       busy_q, busy_d;

    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_rise  = scl_s2_q & ~scl_dly_q;
    assign scl_fall  = ~scl_s2_q & scl_dly_q;
    assign start_det = scl_s2_q & ~sda_s2_q & sda_dly_q;
    assign stop_det  = scl_s2_q & sda_s2_q & ~sda_dly_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        done_d     = done_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        busy_d     = busy_q;

        // Bus conditions win over any same-cycle SCL edge; this also covers repeated START.
        if (start_det) begin
            state_d  = S_ADDR;
            cnt_d    = 3'd0;
            done_d   = 1'b0;
            busy_d   = 1'b1;
            sda_oe_d = 1'b0;
        end else if (stop_det) begin
            state_d  = S_IDLE;
            cnt_d    = 3'd0;
            done_d   = 1'b0;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_DATA: begin
                    if (scl_rise && !done_q) begin
                        shift_d = {shift_q[6:0], sda_s2_q};
                        cnt_d   = cnt_q + 3'd1;
                        done_d  = (cnt_q == 3'd7);
                    end else if (scl_fall && done_q) begin
                        done_d = 1'b0;
                        if (state_q == S_ADDR) begin
                            if (shift_q[7:1] == ADDR && !shift_q[0]) begin
                                state_d  = S_ADDR_ACK;
                                sda_oe_d = 1'b1;
                            end else begin
                                state_d  = S_IGNORE;
                                sda_oe_d = 1'b0;
                            end
                        end else begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            sda_oe_d   = 1'b1;
                            state_d    = S_DATA_ACK;
                        end
                    end
                end
                S_ADDR_ACK, S_DATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 3'd0;
                        done_d   = 1'b0;
                        state_d  = S_DATA;
                    end
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_dly_q  <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_dly_q  <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            shift_q    <= 8'h00;
            done_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_s1_q   <= scl_in;
            scl_s2_q   <= scl_s1_q;
            scl_dly_q  <= scl_s2_q;
            sda_s1_q   <= sda_in;
            sda_s2_q   <= sda_s1_q;
            sda_dly_q  <= sda_s2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            done_q     <= done_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;

endmodule
